// File: rtl/ram_port_arbiter.sv
// Arbitrates the single RAM port between instruction fetch (read-only) and the memory stage.
// Define ROUND_ROBIN_EN to alternate grants under contention instead of fixed MEM-over-IF priority.
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int RAM_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic                    if_done,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [STROBE_WIDTH-1:0] mem_wstrb,
  output logic                    mem_ready,
  output logic                    mem_done,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  output logic                    ram_write_enable,
  output logic [STROBE_WIDTH-1:0] ram_write_strobe,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (RAM_LATENCY > 0) ? $clog2(RAM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LATENCY);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    owner_q, owner_d;   // 1 = MEM owns the access
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                    ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
  logic                    if_done_q, if_done_d;
  logic                    mem_done_q, mem_done_d;
  logic                    mem_win, if_win;
`ifdef ROUND_ROBIN_EN
  logic                    last_grant_q, last_grant_d;  // 1 = MEM was granted last
`endif

  always_comb begin
    mem_win = 1'b0;
    if_win  = 1'b0;
    if (state_q == IDLE && !rst) begin
`ifdef ROUND_ROBIN_EN
      mem_win = mem_req & (~if_req | ~last_grant_q);
`else
      mem_win = mem_req;
`endif
      if_win = if_req & ~mem_win;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ram_we_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_win || if_win) begin
          state_d  = ACCESS;
          cnt_d    = '0;
          owner_d  = mem_win;
          we_d     = mem_win & mem_we;
          ram_we_d = mem_win & mem_we;
          addr_d   = mem_win ? mem_addr : if_addr;
          wdata_d  = mem_win ? mem_wdata : wdata_q;
          wstrb_d  = mem_win ? mem_wstrb : '0;
`ifdef ROUND_ROBIN_EN
          last_grant_d = mem_win;
`endif
        end
      end
      ACCESS: begin
        // Write enable was raised at accept and drops by default after cnt == 0.
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) mem_rdata_d = ram_read_data;
            else         if_rdata_d  = ram_read_data;
          end
          mem_done_d = owner_q;
          if_done_d  = ~owner_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ram_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ram_we_q    <= ram_we_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
`ifdef ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_ready         = if_win;
  assign mem_ready        = mem_win;
  assign if_done          = if_done_q;
  assign mem_done         = mem_done_q;
  assign if_rdata         = if_rdata_q;
  assign mem_rdata        = mem_rdata_q;
  assign ram_address      = addr_q;
  assign ram_write_data   = wdata_q;
  assign ram_write_strobe = wstrb_q;
  assign ram_write_enable = ram_we_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: three instances at RAM latencies 0, 1 and 3, each with its own RAM model.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat [3] = '{0, 1, 3};

  logic        rst [3];
  logic        if_req [3];
  logic [31:0] if_addr [3];
  logic        mem_req [3];
  logic        mem_we [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_wstrb [3];
  logic        if_ready [3];
  logic        if_done [3];
  logic [31:0] if_rdata [3];
  logic        mem_ready [3];
  logic        mem_done [3];
  logic [31:0] mem_rdata [3];
  logic [31:0] ram_addr [3];
  logic [31:0] ram_wdata [3];
  logic        ram_we [3];
  logic [3:0]  ram_wstrb [3];
  logic        busy [3];
  logic [31:0] rdv [3];
  logic [31:0] rd1, rd3_a, rd3_b, rd3;
  logic        ram_clr;

  logic [31:0] wmem [3][256];
  bit          wvalid [3][256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT_G = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    ram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STROBE_WIDTH(4), .RAM_LATENCY(LAT_G)) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]),
      .if_done(if_done[g]), .if_rdata(if_rdata[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]), .mem_ready(mem_ready[g]),
      .mem_done(mem_done[g]), .mem_rdata(mem_rdata[g]),
      .ram_address(ram_addr[g]), .ram_write_data(ram_wdata[g]),
      .ram_write_enable(ram_we[g]), .ram_write_strobe(ram_wstrb[g]),
      .ram_read_data(rdv[g]), .busy(busy[g])
    );
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    if (b == 8'h10) return 32'hDEADBEEF;
    return {b ^ 8'h5A, b, ~b, b + 8'h33};
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
    if (wvalid[k][a[7:0]]) return wmem[k][a[7:0]];
    return pat(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 3; k++) for (int i = 0; i < 256; i++) wvalid[k][i] <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) if (ram_we[k]) begin
        wmem[k][ram_addr[k][7:0]]   <= merge(model_read(k, ram_addr[k]), ram_wdata[k], ram_wstrb[k]);
        wvalid[k][ram_addr[k][7:0]] <= 1'b1;
      end
    end
    rd1   <= model_read(1, ram_addr[1]);
    rd3_a <= model_read(2, ram_addr[2]);
    rd3_b <= rd3_a;
    rd3   <= rd3_b;
  end

  always_comb begin
    rdv[0] = model_read(0, ram_addr[0]);
    rdv[1] = rd1;
    rdv[2] = rd3;
  end

  typedef struct {
    int          dut;
    bit          owner;
    int          due;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] if_last [3];
  logic [31:0] mem_last [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (if_done[k] || mem_done[k]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {30'd0, if_done[k], mem_done[k]}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_dut", k, e.dut);
          chk("done_cycle", cyc, e.due);
          chk("mem_done", {31'd0, mem_done[k]}, {31'd0, e.owner});
          chk("if_done", {31'd0, if_done[k]}, {31'd0, !e.owner});
          chk("if_rdata", if_rdata[k], e.exp_if);
          chk("mem_rdata", mem_rdata[k], e.exp_mem);
        end
      end
    end
  endtask

  task automatic push(input int k, input bit owner, input bit we, input logic [31:0] addr);
    exp_t e;
    if (!we) begin
      if (owner) mem_last[k] = model_read(k, addr);
      else       if_last[k]  = model_read(k, addr);
    end
    e.dut = k; e.owner = owner; e.due = cyc + lat[k] + 2;
    e.exp_if = if_last[k]; e.exp_mem = mem_last[k];
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input int k, input bit is_mem);
    int n;
    n = 0;
    #1;
    while (!(is_mem ? mem_ready[k] : if_ready[k]) && n < 30) begin
      tick();
      #1;
      n++;
    end
    chk(is_mem ? "mem_grant" : "if_grant", {31'd0, is_mem ? mem_ready[k] : if_ready[k]}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain", sbq.size(), 32'd0);
    tick();
  endtask

  task automatic access(input int k, input bit is_mem, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    if (is_mem) begin
      mem_req[k] = 1'b1; mem_we[k] = we; mem_addr[k] = addr; mem_wdata[k] = wdata; mem_wstrb[k] = wstrb;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    wait_grant(k, is_mem);
    push(k, is_mem, we, addr);
    tick();
    if (is_mem) mem_req[k] = 1'b0;
    else        if_req[k]  = 1'b0;
  endtask

  task automatic contend(input int k, input logic [31:0] if_a, input logic [31:0] mem_a, input bit mem_first);
    int t0;
    if_req[k] = 1'b1; if_addr[k] = if_a;
    mem_req[k] = 1'b1; mem_we[k] = 1'b0; mem_addr[k] = mem_a;
    #1;
    chk("cont_mem_ready", {31'd0, mem_ready[k]}, {31'd0, mem_first});
    chk("cont_if_ready", {31'd0, if_ready[k]}, {31'd0, !mem_first});
    t0 = cyc;
    push(k, mem_first, 1'b0, mem_first ? mem_a : if_a);
    tick();
    if (mem_first) mem_req[k] = 1'b0;
    else           if_req[k]  = 1'b0;
    wait_grant(k, !mem_first);
    chk("cont_second_grant_cycle", cyc, t0 + lat[k] + 3);
    push(k, !mem_first, 1'b0, mem_first ? if_a : mem_a);
    tick();
    if_req[k] = 1'b0;
    mem_req[k] = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] p, e;
    bit rr_mem_first;
    ram_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
      mem_req[k] = 1'b0; mem_we[k] = 1'b0; mem_addr[k] = '0; mem_wdata[k] = '0; mem_wstrb[k] = '0;
      if_last[k] = '0; mem_last[k] = '0;
    end
    tick();
    tick();
    ram_clr = 1'b0;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", {31'd0, busy[k]}, 32'd0);
      chk("rst_ram_addr", ram_addr[k], 32'd0);
      chk("rst_ram_we", {31'd0, ram_we[k]}, 32'd0);
      chk("rst_if_rdata", if_rdata[k], 32'd0);
      chk("rst_mem_rdata", mem_rdata[k], 32'd0);
    end

    // Fresh contention on L=1: MEM first in both arbitration modes.
    contend(1, 32'h40, 32'h44, 1'b1);

    // IF read from 0x10 with per-cycle port checks.
    if_req[1] = 1'b1; if_addr[1] = 32'h10;
    wait_grant(1, 1'b0);
    chk("if_mem_ready_low", {31'd0, mem_ready[1]}, 32'd0);
    push(1, 1'b0, 1'b0, 32'h10);
    chk("if_expect_deadbeef", if_last[1], 32'hDEADBEEF);
    tick();
    if_req[1] = 1'b0;
    chk("if_T1_addr", ram_addr[1], 32'h10);
    chk("if_T1_we", {31'd0, ram_we[1]}, 32'd0);
    chk("if_T1_busy", {31'd0, busy[1]}, 32'd1);
    chk("if_T1_ready", {31'd0, if_ready[1]}, 32'd0);
    tick();
    chk("if_T2_addr", ram_addr[1], 32'h10);
    chk("if_T2_we", {31'd0, ram_we[1]}, 32'd0);
    drain();
    chk("idle_busy", {31'd0, busy[1]}, 32'd0);
    chk("idle_addr_held", ram_addr[1], 32'h10);

    access(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    drain();

`ifdef ROUND_ROBIN_EN
    rr_mem_first = 1'b0;
`else
    rr_mem_first = 1'b1;
`endif
    contend(1, 32'h4C, 32'h48, rr_mem_first);

    // Byte write: strobe passes through, enable only in the first access cycle.
    access(1, 1'b1, 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
    chk("wr_T1_we", {31'd0, ram_we[1]}, 32'd1);
    chk("wr_T1_strb", {28'd0, ram_wstrb[1]}, 32'h2);
    chk("wr_T1_wdata", ram_wdata[1], 32'h0000AB00);
    chk("wr_T1_addr", ram_addr[1], 32'h20);
    tick();
    chk("wr_T2_we", {31'd0, ram_we[1]}, 32'd0);
    drain();
    p = pat(32'h20);
    e = {p[31:16], 8'hAB, p[7:0]};
    chk("wr_ram_byte1", model_read(1, 32'h20), e);

    access(1, 1'b1, 1'b1, 32'h24, 32'hFFFFFFFF, 4'b0000);
    chk("wr0_T1_we", {31'd0, ram_we[1]}, 32'd1);
    chk("wr0_T1_strb", {28'd0, ram_wstrb[1]}, 32'h0);
    drain();
    chk("wr0_ram_unchanged", model_read(1, 32'h24), pat(32'h24));
    mem_we[1] = 1'b0;

    // Latency 0: combinational RAM read.
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    drain();
    access(0, 1'b1, 1'b1, 32'h60, 32'h12345678, 4'hF);
    drain();
    access(0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
    drain();
    chk("l0_mem_rdata", mem_rdata[0], 32'h12345678);

    // Latency 3 read.
    access(2, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    drain();
    chk("l3_mem_rdata", mem_rdata[2], pat(32'h14));

    // Reset in the middle of a latency-3 write, with a new request pending.
    mem_req[2] = 1'b1; mem_we[2] = 1'b1; mem_addr[2] = 32'h50; mem_wdata[2] = 32'hAAAA5555; mem_wstrb[2] = 4'hF;
    wait_grant(2, 1'b1);
    tick();
    mem_req[2] = 1'b0;
    chk("rstmid_T1_we", {31'd0, ram_we[2]}, 32'd1);
    tick();
    rst[2] = 1'b1;
    mem_req[2] = 1'b1; mem_addr[2] = 32'h54; mem_wdata[2] = 32'h0BADF00D;
    tick();
    rst[2] = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy[2]}, 32'd0);
    chk("rstmid_ram_addr", ram_addr[2], 32'd0);
    chk("rstmid_ram_wdata", ram_wdata[2], 32'd0);
    chk("rstmid_ram_we", {31'd0, ram_we[2]}, 32'd0);
    chk("rstmid_ram_strb", {28'd0, ram_wstrb[2]}, 32'd0);
    chk("rstmid_mem_done", {31'd0, mem_done[2]}, 32'd0);
    chk("rstmid_mem_rdata", mem_rdata[2], 32'd0);
    chk("rstmid_reaccept", {31'd0, mem_ready[2]}, 32'd1);
    if_last[2] = '0;
    mem_last[2] = '0;
    push(2, 1'b1, 1'b1, 32'h54);
    tick();
    mem_req[2] = 1'b0;
    drain();
    chk("rstmid_ram_written", model_read(2, 32'h54), 32'h0BADF00D);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
